fft_frame_buffer: RTL and testbench



---
 rtl/fft_frame_buffer.sv | 131 +++++++++++++
 tb/tb_fft_frame_buffer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_buffer.sv
// fft_frame_buffer: ping-pong input buffer for the first FFT butterfly stage.
// Streams WIDTH-bit samples in over valid/ready, collects SAMPLES of them per
// bank, and presents the finished bank as a parallel frame with its own
// valid/ready handshake while the other bank fills.
// Build option: define FFT_FRAME_BITREV_EN to store each sample at its
// bit-reversed index (DIT input order); otherwise natural order is used.
module fft_frame_buffer #(
  parameter int SAMPLES = 4,
  parameter int WIDTH   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_sync,
  output logic             in_ready,
  output logic [WIDTH-1:0] frame_data [SAMPLES-1:0],
  output logic             frame_valid,
  input  logic             frame_ready
);

  localparam int LOG2 = $clog2(SAMPLES);
  localparam logic [LOG2-1:0] LAST_IDX = LOG2'(SAMPLES - 1);

  // Reverse the bit order of an index across LOG2 bits.
  function automatic logic [LOG2-1:0] bitrev(input logic [LOG2-1:0] v);
    logic [LOG2-1:0] r;
    r = '0;
    for (int b = 0; b < LOG2; b++) begin
      r[b] = v[LOG2-1-b];
    end
    return r;
  endfunction

  // Sample storage: bank_q[bank][position].
  logic [WIDTH-1:0] bank_q [0:1][0:SAMPLES-1];

  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;
  logic [1:0]      full_q, full_d;
  logic [LOG2-1:0] wr_cnt_q, wr_cnt_d;

  logic            accept_s;
  logic            take_s;
  logic            last_s;
  logic [LOG2-1:0] idx_s;
  logic [LOG2-1:0] pos_s;

  // Handshake outputs are pure decodes of state registers, so no
  // combinational path exists from frame_ready or in_valid.
  assign in_ready    = !full_q[wr_bank_q];
  assign frame_valid = full_q[rd_bank_q];

  // Present the read bank as the parallel frame.
  always_comb begin
    for (int i = 0; i < SAMPLES; i++) begin
      frame_data[i] = bank_q[rd_bank_q][i];
    end
  end

  // Accept/take decode and next-state for the bank bookkeeping.
  always_comb begin
    accept_s  = in_valid && in_ready;
    take_s    = frame_valid && frame_ready;
    idx_s     = in_sync ? '0 : wr_cnt_q;
`ifdef FFT_FRAME_BITREV_EN
    pos_s     = bitrev(idx_s);
`else
    pos_s     = idx_s;
`endif
    last_s    = (idx_s == LAST_IDX);
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    wr_cnt_d  = wr_cnt_q;

    if (accept_s) begin
      if (last_s) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_cnt_d          = '0;
      end else if (in_sync) begin
        // A sync restarts the frame: the stale partial entries are simply
        // overwritten by the writes that follow.
        wr_cnt_d = LOG2'(1);
      end else begin
        wr_cnt_d = wr_cnt_q + LOG2'(1);
      end
    end else begin
      wr_cnt_d = wr_cnt_q;
    end

    // A take always targets the other bank from any completion this cycle,
    // because a completion needs that bank empty and a take needs it full.
    if (take_s) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end else begin
      rd_bank_d = rd_bank_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= 2'b00;
      wr_cnt_q  <= '0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  // Bank storage: cleared on reset, one word written per accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < SAMPLES; i++) begin
          bank_q[b][i] <= '0;
        end
      end
    end else if (accept_s) begin
      bank_q[wr_bank_q][pos_s] <= in_data;
    end
  end

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Scoreboard bench for fft_frame_buffer (SAMPLES=4, WIDTH=32).
// The reference model collects accepted samples into a list and, when a
// frame is complete, places sample k at its (optionally bit-reversed) slot.
module tb_fft_frame_buffer;

  localparam int S    = 4;
  localparam int W    = 32;
  localparam int LOG2 = 2;

  typedef logic [S-1:0][W-1:0] frame_t;

  logic         clk;
  logic         reset;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_sync;
  logic         in_ready;
  logic [W-1:0] frame_data [3:0];
  logic         frame_valid;
  logic         frame_ready;

  int n_cmp = 0;
  int n_err = 0;
  int takes = 0;

  frame_t       sb[$];
  logic [W-1:0] part[$];

  fft_frame_buffer #(.SAMPLES(S), .WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_sync     (in_sync),
    .in_ready    (in_ready),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int brev(input int k);
    int r;
    r = 0;
    for (int b = 0; b < LOG2; b++) begin
      if (k[b]) r = r | (1 << (LOG2 - 1 - b));
    end
    return r;
  endfunction

  // Reference model: a sync starts a new frame; four samples make a frame.
  task automatic model_accept(input logic [W-1:0] d, input logic s);
    frame_t f;
    if (s) part.delete();
    part.push_back(d);
    if (part.size() == S) begin
      for (int k = 0; k < S; k++) begin
`ifdef FFT_FRAME_BITREV_EN
        f[brev(k)] = part[k];
`else
        f[k] = part[k];
`endif
      end
      sb.push_back(f);
      part.delete();
    end
  endtask

  // Offer one sample and hold it until accepted (bounded).
  task automatic send(input logic [W-1:0] d, input logic s);
    bit acc;
    int t;
    acc = 1'b0;
    t   = 0;
    in_data  = d;
    in_sync  = s;
    in_valid = 1'b1;
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    if (acc) begin
      model_accept(d, s);
    end else begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: sample %0d not accepted within 200 cycles", d);
    end
    in_valid = 1'b0;
    in_sync  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compares handshakes against the model and pops on every take.
  initial begin
    frame_t held;
    frame_t e;
    bit     hold_v;
    hold_v = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_v = 1'b0;
      end else begin
        chk("frame_valid", W'(frame_valid), W'(sb.size() > 0));
        chk("in_ready", W'(in_ready), W'(sb.size() < 2));
        if (hold_v && frame_valid) begin
          for (int i = 0; i < S; i++) chk("stable", frame_data[i], held[i]);
        end
        hold_v = frame_valid && !frame_ready;
        if (hold_v) begin
          for (int i = 0; i < S; i++) held[i] = frame_data[i];
        end
        if (frame_valid && frame_ready && sb.size() > 0) begin
          e = sb.pop_front();
          for (int i = 0; i < S; i++) chk("frame_data", frame_data[i], e[i]);
          takes++;
        end
      end
    end
  end

  initial begin
    logic [W-1:0] exp1 [4];
    int  t0;
    bit  done;
    reset       = 1'b1;
    in_data     = '0;
    in_valid    = 1'b0;
    in_sync     = 1'b0;
    frame_ready = 1'b0;
    idle(2);
    reset = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("rst_frame_valid", W'(frame_valid), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(1));
    for (int i = 0; i < S; i++) chk("rst_frame_data", frame_data[i], '0);
    idle(1);

    // Ordering: 10..13 with sync on 10, valid one cycle after 4th accept.
    frame_ready = 1'b1;
    send(32'd10, 1'b1);
    send(32'd11, 1'b0);
    send(32'd12, 1'b0);
    send(32'd13, 1'b0);
`ifdef FFT_FRAME_BITREV_EN
    exp1[0] = 32'd10; exp1[1] = 32'd12; exp1[2] = 32'd11; exp1[3] = 32'd13;
`else
    exp1[0] = 32'd10; exp1[1] = 32'd11; exp1[2] = 32'd12; exp1[3] = 32'd13;
`endif
    @(negedge clk);
    chk("order_valid", W'(frame_valid), W'(1));
    for (int i = 0; i < S; i++) chk("order_data", frame_data[i], exp1[i]);
    idle(3);

    // Back-pressure: two banks fill, sample 9 stalls until a one-cycle take.
    frame_ready = 1'b0;
    for (int v = 1; v <= 8; v++) send(W'(v), v == 1);
    fork
      send(32'd9, 1'b0);
      begin
        repeat (4) begin
          @(negedge clk);
          chk("bp_in_ready", W'(in_ready), W'(0));
          chk("bp_head", frame_data[0], 32'd1);
        end
        @(posedge clk);
        #1 frame_ready = 1'b1;
        @(posedge clk);
        #1 frame_ready = 1'b0;
        @(negedge clk);
        chk("bp_next_head", frame_data[0], 32'd5);
      end
    join
    frame_ready = 1'b1;
    send(32'd10, 1'b0);
    send(32'd11, 1'b0);
    send(32'd12, 1'b0);
    idle(4);

    // Full rate: 40 back-to-back samples, 10 frames.
    t0 = takes;
    for (int i = 0; i < 40; i++) send($urandom, i == 0);
    idle(3);
    chk("fullrate_frames", W'(takes - t0), W'(10));

    // Mid-frame sync discards 1,2.
    t0 = takes;
    send(32'd1, 1'b1);
    send(32'd2, 1'b0);
    send(32'd5, 1'b1);
    send(32'd6, 1'b0);
    send(32'd7, 1'b0);
    send(32'd8, 1'b0);
    idle(3);
    chk("midsync_frames", W'(takes - t0), W'(1));

    // Reset with one full bank and two pending samples.
    frame_ready = 1'b0;
    for (int v = 1; v <= 6; v++) send(W'(v), v == 1 || v == 5);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    part.delete();
    sb.delete();
    @(negedge clk);
    chk("mrst_frame_valid", W'(frame_valid), W'(0));
    chk("mrst_in_ready", W'(in_ready), W'(1));
    for (int i = 0; i < S; i++) chk("mrst_frame_data", frame_data[i], '0);
    idle(1);
    frame_ready = 1'b1;
    for (int v = 20; v <= 23; v++) send(W'(v), v == 20);
    @(negedge clk);
    chk("mrst_latency_valid", W'(frame_valid), W'(1));
    idle(2);

    // Randomized traffic with random syncs, gaps and back-pressure.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(3) == 0) idle(1);
          send($urandom, $urandom_range(7) == 0);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          frame_ready = ($urandom_range(9) < 7);
          @(posedge clk);
          #1;
        end
      end
    join
    frame_ready = 1'b1;
    idle(6);
    chk("drain_empty", W'(sb.size()), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
